booth_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier. It replaces the fully unrolled 8-bit combinational multiplier with a single iteration stage that is reused over W+1 clock cycles. It adds a per-operation signed/unsigned mode and valid/ready handshakes on both sides. It sits wherever an area-cheap multiply with multi-cycle latency is acceptable, such as an ALU multiply unit or a DSP control path.

---
 rtl/booth_pkg.sv | 36 +++
 rtl/booth_step.sv | 42 ++++
 rtl/booth_seq.sv | 116 +++++++++++
 tb/tb_booth_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg : shared types and helpers for the sequential Booth multiplier
// Revision  : 1.0
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Counter must hold W+1, so $clog2(W+2) bits are always enough.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// booth_step : one combinational radix-2 Booth iteration on {A, Q_r, q_1}
// Revision   : 1.0
// ============================================================================
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc_i,
    input  logic [WIDTH:0]   mplr_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   mcand_i,
    output logic [WIDTH+1:0] acc_o,
    output logic [WIDTH:0]   mplr_o,
    output logic             qm1_o
);

    booth_op_t        w_op;
    logic [WIDTH+1:0] w_mcand_ext;
    logic [WIDTH+1:0] w_sum;

    assign w_op        = booth_decode(mplr_i[0], qm1_i);
    assign w_mcand_ext = {mcand_i[WIDTH], mcand_i};

    always_comb begin
        w_sum = acc_i;
        case (w_op)
            OP_ADD:  w_sum = acc_i + w_mcand_ext;
            OP_SUB:  w_sum = acc_i - w_mcand_ext;
            default: w_sum = acc_i;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, Q_r, q_1}.
    assign acc_o  = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign mplr_o = {w_sum[0], mplr_i[WIDTH:1]};
    assign qm1_o  = mplr_i[0];

endmodule
`default_nettype wire

// File: rtl/booth_seq.sv
`default_nettype none
// ============================================================================
// booth_seq : sequential radix-2 Booth multiplier, signed/unsigned per op,
//             valid/ready handshakes, W+1 cycle latency
// Revision  : 1.0
// ============================================================================
module booth_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int            CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(WIDTH + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

    state_t               state_q;
    logic [WIDTH+1:0]     acc_q;
    logic [WIDTH:0]       mplr_q;
    logic [WIDTH:0]       mcand_q;
    logic                 qm1_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [WIDTH+1:0]     acc_d;
    logic [WIDTH:0]       mplr_d;
    logic                 qm1_d;
    logic [WIDTH:0]       w_mcand_ext;
    logic [WIDTH:0]       w_mplr_ext;

    assign w_mcand_ext = {is_signed & multiplicand[WIDTH-1], multiplicand};
    assign w_mplr_ext  = {is_signed & multiplier[WIDTH-1],   multiplier};

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .mplr_i  (mplr_q),
        .qm1_i   (qm1_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_d),
        .mplr_o  (mplr_d),
        .qm1_o   (qm1_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mplr_q      <= '0;
            mcand_q     <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_q <= w_mcand_ext;
                        mplr_q  <= w_mplr_ext;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= C_CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    qm1_q  <= qm1_d;
                    cnt_q  <= cnt_q - C_CNT_LAST;
                    // Product is the low 2W bits of {A, Q_r} after the final step.
                    if (cnt_q == C_CNT_LAST) begin
                        product_q   <= {acc_d[WIDTH-2:0], mplr_d};
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq.sv
`default_nettype none
// ============================================================================
// tb_booth_seq : directed and random scoreboard bench for booth_seq (W=8, W=16)
// Revision     : 1.0
// ============================================================================
module tb_booth_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv8, is8, ordy8, irdy8, ov8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    logic        iv16, is16, ordy16, irdy16, ov16, busy16;
    logic [15:0] m16, q16;
    logic [31:0] p16;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_in8 = 0, n_out8 = 0, n_in16 = 0, n_out16 = 0;
    int          lat;
    logic [31:0] sb8[$];
    logic [31:0] sb16[$];

    always #5 clk = ~clk;

    booth_seq #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst),
        .in_valid (iv8), .in_ready (irdy8), .is_signed (is8),
        .multiplicand (m8), .multiplier (q8),
        .out_valid (ov8), .out_ready (ordy8), .product (p8), .busy (busy8)
    );

    booth_seq #(.WIDTH(16)) u_dut16 (
        .clk (clk), .rst (rst),
        .in_valid (iv16), .in_ready (irdy16), .is_signed (is16),
        .multiplicand (m16), .multiplier (q16),
        .out_valid (ov16), .out_ready (ordy16), .product (p16), .busy (busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] get_prod(input bit wide);
        return wide ? p16 : {16'b0, p8};
    endfunction
    function automatic logic [31:0] get_ov(input bit wide);
        return {31'b0, wide ? ov16 : ov8};
    endfunction
    function automatic logic [31:0] get_irdy(input bit wide);
        return {31'b0, wide ? irdy16 : irdy8};
    endfunction
    function automatic logic [31:0] get_busy(input bit wide);
        return {31'b0, wide ? busy16 : busy8};
    endfunction

    function automatic logic [31:0] ref_mul(input bit wide, input bit sgn,
                                            input logic [15:0] m, input logic [15:0] q);
        longint      a, b, p;
        logic [63:0] pv;
        if (wide) begin
            a = sgn ? longint'($signed(m)) : longint'(m);
            b = sgn ? longint'($signed(q)) : longint'(q);
        end else begin
            a = sgn ? longint'($signed(m[7:0])) : longint'(m[7:0]);
            b = sgn ? longint'($signed(q[7:0])) : longint'(q[7:0]);
        end
        p  = a * b;
        pv = p;
        return wide ? pv[31:0] : {16'b0, pv[15:0]};
    endfunction

    task automatic drive_in(input bit wide, input bit v, input bit sgn,
                            input logic [15:0] m, input logic [15:0] q);
        if (wide) begin
            iv16 = v; is16 = sgn; m16 = m; q16 = q;
        end else begin
            iv8 = v; is8 = sgn; m8 = m[7:0]; q8 = q[7:0];
        end
    endtask

    task automatic set_ordy(input bit wide, input bit v);
        if (wide) ordy16 = v;
        else      ordy8  = v;
    endtask

    // Presents one operation and pushes its expected product; returns 1ns after the accept edge.
    task automatic start(input bit wide, input bit sgn, input logic [15:0] m,
                         input logic [15:0] q, input logic [31:0] exp);
        int guard = 0;
        while (get_irdy(wide) != 32'd1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("start_ready", get_irdy(wide), 32'd1);
        drive_in(wide, 1'b1, sgn, m, q);
        if (wide) begin sb16.push_back(exp); n_in16++; end
        else      begin sb8.push_back(exp);  n_in8++;  end
        @(posedge clk); #1;
        drive_in(wide, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Waits for out_valid, holds backpressure for `hold` cycles while poking in_valid, then accepts.
    task automatic collect(input bit wide, input int hold, output int latency);
        logic [31:0] exp;
        latency = 0;
        while (get_ov(wide) != 32'd1 && latency < 60) begin
            @(posedge clk); #1;
            latency++;
        end
        check("out_valid_seen", get_ov(wide), 32'd1);
        exp = 32'hDEAD_BEEF;
        if (wide) begin if (sb16.size() > 0) exp = sb16.pop_front(); end
        else      begin if (sb8.size()  > 0) exp = sb8.pop_front();  end
        check("product", get_prod(wide), exp);
        for (int i = 0; i < hold; i++) begin
            drive_in(wide, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            check("hold_valid",   get_ov(wide),   32'd1);
            check("hold_product", get_prod(wide), exp);
            check("hold_busy",    get_busy(wide), 32'd1);
            check("hold_ready",   get_irdy(wide), 32'd0);
        end
        drive_in(wide, 1'b0, 1'b0, 16'h0, 16'h0);
        set_ordy(wide, 1'b1);
        @(posedge clk); #1;
        set_ordy(wide, 1'b0);
        if (wide) n_out16++;
        else      n_out8++;
        check("release_valid",   get_ov(wide),   32'd0);
        check("release_ready",   get_irdy(wide), 32'd1);
        check("release_product", get_prod(wide), exp);
    endtask

    initial begin
        rst = 1'b1;
        drive_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        ordy8 = 1'b0; ordy16 = 1'b0;
        #12;
        check("rst_in_ready",  get_irdy(1'b0), 32'd1);
        check("rst_out_valid", get_ov(1'b0),   32'd0);
        check("rst_busy",      get_busy(1'b0), 32'd0);
        check("rst_product",   get_prod(1'b0), 32'd0);
        check("rst_product16", get_prod(1'b1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed corner: -128 * -128, exact W+1 latency.
        start(1'b0, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000);
        check("calc_busy",  get_busy(1'b0), 32'd1);
        check("calc_ready", get_irdy(1'b0), 32'd0);
        collect(1'b0, 0, lat);
        check("corner_latency", 32'(lat), 32'd9);

        start(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01);
        collect(1'b0, 0, lat);
        start(1'b0, 1'b1, 16'h00FF, 16'h00FF, 32'h0000_0001);
        collect(1'b0, 0, lat);
        start(1'b0, 1'b1, 16'h0000, 16'h0080, 32'h0000_0000);
        collect(1'b0, 0, lat);

        // Mixed signs under 5 cycles of backpressure.
        start(1'b0, 1'b1, 16'h0007, 16'h00FD, 32'h0000_FFEB);
        collect(1'b0, 5, lat);

        // Asynchronous reset during the fourth CALC cycle discards the operation.
        start(1'b0, 1'b0, 16'd200, 16'd100, 32'd20000);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", get_ov(1'b0),   32'd0);
        check("arst_product",   get_prod(1'b0), 32'd0);
        check("arst_in_ready",  get_irdy(1'b0), 32'd1);
        check("arst_busy",      get_busy(1'b0), 32'd0);
        void'(sb8.pop_back());
        n_in8--;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        start(1'b0, 1'b0, 16'd3, 16'd5, 32'd15);
        collect(1'b0, 0, lat);
        check("post_rst_latency", 32'(lat), 32'd9);

        // Random regression, both widths and modes, random backpressure.
        for (int i = 0; i < 40; i++) begin
            bit          wide;
            bit          sgn;
            logic [15:0] m, q;
            wide = (i % 2) == 1;
            sgn  = 1'($urandom_range(0, 1));
            m    = 16'($urandom);
            q    = 16'($urandom);
            if (!wide) begin
                m[15:8] = 8'h00;
                q[15:8] = 8'h00;
            end
            start(wide, sgn, m, q, ref_mul(wide, sgn, m, q));
            collect(wide, $urandom_range(0, 3), lat);
            check("rand_latency", 32'(lat), wide ? 32'd17 : 32'd9);
        end

        repeat (25) @(posedge clk);
        #1;
        check("idle_no_spurious8",  get_ov(1'b0), 32'd0);
        check("idle_no_spurious16", get_ov(1'b1), 32'd0);
        check("count8",  32'(n_out8),  32'(n_in8));
        check("count16", 32'(n_out16), 32'(n_in16));
        check("sb8_empty",  32'(sb8.size()),  32'd0);
        check("sb16_empty", 32'(sb16.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
